// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Optional writer locking is enabled with the FIFO_ARB_LOCK_EN macro.
package fifo_arb_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  // Round-robin pointer step: the writer after idx, wrapping n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// scanning upward modulo NREQ.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int pos;
      pos = int'(ptr_i) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!any_o && req_i[pos]) begin
        any_o        = 1'b1;
        idx_o        = IW'(pos);
        grant_o[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NREQ writers into one FIFO write port through a
// single output register. Define FIFO_ARB_LOCK_EN to add the req_lock input.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
`ifdef FIFO_ARB_LOCK_EN
  input  logic [NREQ-1:0]           req_lock,
`endif
  input  logic                      fifo_ready,
  output logic                      fifo_wr_en,
  output logic [WIDTH-1:0]          fifo_data,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);

  arb_state_e        state_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  data_q;
  logic [IW-1:0]     gid_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     ptr_d;

  logic [NREQ-1:0]   pick_grant;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  logic [NREQ-1:0]   win_grant;
  logic [IW-1:0]     win_idx;
  logic              win_any;
  logic              stage_free;
  logic              accept;
  logic [WIDTH-1:0]  win_data;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

`ifdef FIFO_ARB_LOCK_EN
  logic last_vld_q;
  logic lock_hit;

  // A locking writer keeps the port only while it is also still presenting data.
  assign lock_hit = last_vld_q && req_lock[gid_q] && req_valid[gid_q];

  always_comb begin
    win_grant = pick_grant;
    win_idx   = pick_idx;
    win_any   = pick_any;
    if (lock_hit) begin
      win_grant        = '0;
      win_grant[gid_q] = 1'b1;
      win_idx          = gid_q;
      win_any          = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_vld_q <= 1'b0;
    end else if (accept) begin
      last_vld_q <= 1'b1;
    end
  end
`else
  assign win_grant = pick_grant;
  assign win_idx   = pick_idx;
  assign win_any   = pick_any;
`endif

  assign stage_free = !out_valid_q || fifo_ready;
  assign accept     = nrst && stage_free && win_any;
  assign req_ready  = (nrst && stage_free) ? win_grant : '0;
  assign win_data   = req_data[int'(win_idx)*WIDTH +: WIDTH];
  assign ptr_d      = IW'(wrap_inc(int'(win_idx), NREQ));

  // Output register and its state; an accept may coincide with draining the held word.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      gid_q       <= '0;
      ptr_q       <= '0;
    end else begin
      if (accept) begin
        data_q <= win_data;
        gid_q  <= win_idx;
        ptr_q  <= ptr_d;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= SEND;
            out_valid_q <= 1'b1;
          end
        end
        SEND, STALL: begin
          if (accept) begin
            state_q     <= SEND;
            out_valid_q <= 1'b1;
          end else if (fifo_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end else begin
            state_q     <= STALL;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_wr_en = out_valid_q && fifo_ready;
  assign fifo_data  = data_q;
  assign grant_id   = gid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of writers sharing one FIFO write port (2..16).
REQ-002 Parameter WIDTH, default 8: data word width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-writer word available.
REQ-006 req_data  input  NREQ*WIDTH  per-writer word; writer i at bits [i*WIDTH +: WIDTH].
REQ-007 req_ready  output  NREQ  per-writer accept, one-hot or zero.
REQ-008 fifo_ready  input  1  FIFO not full (from FIFO ready).
REQ-009 fifo_wr_en  output  1  write strobe to FIFO.
REQ-010 fifo_data  output  WIDTH  word to FIFO.
REQ-011 grant_id  output  $clog2(NREQ)  index of writer owning fifo_data.
REQ-012 busy  output  1  high when state is not IDLE.

Function
REQ-013 Output stage SHALL be one register (out_valid, fifo_data, grant_id); fifo_wr_en = out_valid && fifo_ready.
REQ-014 States: IDLE (out_valid=0), SEND (out_valid=1, fifo_ready=1), STALL (out_valid=1, fifo_ready=0).
REQ-015 Transitions: IDLE->SEND on accept; SEND->SEND on accept, ->IDLE on no accept; SEND/IDLE never go to STALL directly except SEND->STALL when fifo_ready falls; STALL->SEND when fifo_ready rises.
REQ-016 Output stage is free when !out_valid || fifo_ready; req_ready SHALL be zero when not free.
REQ-017 When free, winner = first i with req_valid[i] scanning rr_ptr, rr_ptr+1, ... modulo NREQ; req_ready[winner]=1 only.
REQ-018 Accept (req_valid[i] && req_ready[i]) SHALL load req_data[i] and i into the output stage; word reaches fifo_data on the next cycle (latency 1).
REQ-019 On accept, rr_ptr <= (winner+1) mod NREQ, wrapping NREQ-1 -> 0; no accept leaves rr_ptr unchanged.
REQ-020 During STALL, fifo_data and grant_id SHALL hold stable; no word dropped or duplicated.
REQ-021 Accept and FIFO write in the same cycle SHALL be allowed (full throughput, one word per cycle).
REQ-022 fifo_ready low with no pending word SHALL not block IDLE; grant waits for free stage only.

Reset
REQ-023 nrst low SHALL immediately force: state IDLE, out_valid 0, fifo_wr_en 0, fifo_data 0, grant_id 0, req_ready 0, busy 0, rr_ptr 0.
REQ-024 Reset mid-STALL SHALL discard the held word; first grant after reset starts scan at writer 0.

Configuration
REQ-025 Macro FIFO_ARB_LOCK_EN: adds input req_lock (NREQ); while the last-accepted writer holds req_lock and req_valid, it SHALL win every free cycle regardless of rr_ptr; rr_ptr advances when lock drops.
REQ-026 Without FIFO_ARB_LOCK_EN: no req_lock port; pure round-robin per REQ-017.

Structure
REQ-027 Package fifo_arb_pkg SHALL hold the state enum (IDLE, SEND, STALL) and default NREQ/WIDTH constants.
REQ-028 Sub-module rr_picker SHALL be combinational: inputs req vector and rr_ptr, outputs one-hot grant, index, any.

Verification
REQ-029 Reset: nrst low mid-traffic -> all outputs 0 same cycle, rr_ptr 0 after release.
REQ-030 All 4 valid, fifo_ready=1, data 0xA0..0xA3 -> fifo_data order A0,A1,A2,A3,A0, one write per cycle.
REQ-031 Only writer 3 valid then writers 0 and 3 -> grant 3 then 0 (rr_ptr wrap 3->0).
REQ-032 fifo_ready low 5 cycles while holding 0x5C -> fifo_wr_en 0, fifo_data 0x5C stable, req_ready 0; single write of 0x5C on recovery.
REQ-033 FIFO_ARB_LOCK_EN, writer 1 locked 3 words with all valid -> grants 1,1,1, then 2.
